sys_tx_fifo: RTL

//  Single-clock, first-word-fall-through (FWFT) FIFO that buffers response bytes from the

---
 rtl/sys_tx_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/sys_tx_fifo.sv
// First-word-fall-through byte FIFO between the system controller and the UART transmitter.
// Full/empty are registered start-of-cycle flags; overflow/underflow are sticky debug flags.
module sys_tx_fifo #(
  parameter int Data_width    = 8,
  parameter int Depth         = 8,
  parameter int Address_width = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [Data_width-1:0]    WR_DATA,
  input  logic                     WR_EN,
  output logic                     FIFO_full,
  output logic                     ALMOST_FULL,
  input  logic                     RD_INC,
  output logic [Data_width-1:0]    RD_DATA,
  output logic                     EMPTY,
  output logic [Address_width:0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  input  logic                     CLR_ERR
);

  localparam int CW = Address_width + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(Depth);
  localparam logic [CW-1:0] AFULL_C  = CW'(Depth - 1);

  logic [Data_width-1:0] mem_q [Depth];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt_d;
  logic          full_q, full_d, empty_q, empty_d, afull_q, afull_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_acc, rd_acc;

  always_comb begin
    wr_acc   = WR_EN & ~full_q;
    rd_acc   = RD_INC & ~empty_q;
    wr_ptr_d = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d = rd_ptr_q + CW'(rd_acc);
    cnt_d    = wr_ptr_d - rd_ptr_d;
    full_d   = (cnt_d == DEPTH_C);
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= AFULL_C);
    // A new violation in the same cycle as CLR_ERR must stay visible.
    ovf_d    = (ovf_q & ~CLR_ERR) | (WR_EN & full_q);
    udf_d    = (udf_q & ~CLR_ERR) | (RD_INC & empty_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is intentionally unreset; a write during reset is discarded.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) mem_q[wr_ptr_q[Address_width-1:0]] <= WR_DATA;
  end

  assign FIFO_full   = full_q;
  assign ALMOST_FULL = afull_q;
  assign EMPTY       = empty_q;
  assign COUNT       = wr_ptr_q - rd_ptr_q;
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = udf_q;
  assign RD_DATA     = empty_q ? '0 : mem_q[rd_ptr_q[Address_width-1:0]];

endmodule
